gsrl_bank_seq: RTL and testbench

- Sequencer and arbiter for a bank of NLATCH gated SR latches (S, R, En per latch, Q/Qn outputs).
- Accepts set/reset commands from NREQ requesters and arbitrates round-robin.
- Drives each latch with a safe setup -> enable-pulse -> hold sequence, so S and R are never both high and never change while En is high.
- Sits between control logic and the latch bank. It is the only driver of the bank's S/R/En.

---
 rtl/gsrl_bank_seq.sv | 135 +++++++++++++
 tb/tb_gsrl_bank_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gsrl_bank_seq.sv
// Round-robin sequencer for a bank of gated SR latches: setup -> En pulse -> hold -> ack.
// GSRL_BANK_READBACK_CHECK_EN adds a Q readback check that raises err on mismatch.
module gsrl_bank_seq #(
   parameter int NREQ      = 4,
   parameter int NLATCH    = 8,
   parameter int IDXW      = 3,
   parameter int PULSE_CYC = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_op,
   input  logic [NREQ*IDXW-1:0]   req_idx,
   output logic [NREQ-1:0]        gnt,
   output logic                   err,
   output logic [NLATCH-1:0]      latch_s,
   output logic [NLATCH-1:0]      latch_r,
   output logic [NLATCH-1:0]      latch_en,
   input  logic [NLATCH-1:0]      latch_q,
   output logic                   busy
);

   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW   = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   localparam int NIDX = 1 << IDXW;
   // Bit i set when index i addresses a real latch.
   localparam logic [NIDX-1:0] VMAP = (NLATCH >= NIDX) ? {NIDX{1'b1}}
                                    : NIDX'((64'd1 << NLATCH) - 64'd1);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, ACK} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     win_id;
   logic              win_op;
   logic [IDXW-1:0]   win_idx;
   logic              win_ok;
   logic [NLATCH-1:0] win_sel;

   logic              any;
   logic [PW-1:0]     pick;
   logic [IDXW-1:0]   pick_idx;
   logic              pick_ok;
   logic [NLATCH-1:0] pick_sel;
   logic              rb_bad;
   int                arb_j;

   always_comb begin
      any   = 1'b0;
      pick  = '0;
      arb_j = 0;
      for (int i = 0; i < NREQ; i++) begin
         arb_j = (int'(ptr) + i) % NREQ;
         if (!any && req[arb_j]) begin
            any  = 1'b1;
            pick = PW'(arb_j);
         end
      end
   end

   assign pick_idx = req_idx[int'(pick)*IDXW +: IDXW];
   assign pick_ok  = VMAP[pick_idx];
   assign pick_sel = pick_ok ? (NLATCH'(1) << pick_idx) : '0;
   assign win_sel  = win_ok ? (NLATCH'(1) << win_idx) : '0;
   assign busy     = (state != IDLE);

`ifdef GSRL_BANK_READBACK_CHECK_EN
   // Q is sampled during HOLD: En has already fallen, so the latch has captured.
   assign rb_bad = win_ok && (latch_q[win_idx] != win_op);
`else
   logic unused_q;
   assign unused_q = ^latch_q;
   assign rb_bad   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ptr      <= '0;
         win_id   <= '0;
         win_op   <= 1'b0;
         win_idx  <= '0;
         win_ok   <= 1'b0;
         gnt      <= '0;
         err      <= 1'b0;
         latch_s  <= '0;
         latch_r  <= '0;
         latch_en <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  win_id  <= pick;
                  win_op  <= req_op[pick];
                  win_idx <= pick_idx;
                  win_ok  <= pick_ok;
                  latch_s <= req_op[pick] ? pick_sel : '0;
                  latch_r <= req_op[pick] ? '0 : pick_sel;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               latch_en <= win_sel;
               cnt      <= '0;
               state    <= PULSE;
            end
            PULSE: begin
               if (cnt == CW'(PULSE_CYC - 1)) begin
                  latch_en <= '0;
                  state    <= HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               latch_s <= '0;
               latch_r <= '0;
               gnt     <= NREQ'(1) << win_id;
               err     <= ~win_ok | rb_bad;
               state   <= ACK;
            end
            ACK: begin
               gnt   <= '0;
               err   <= 1'b0;
               ptr   <= (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gsrl_bank_seq.sv
// Bench for gsrl_bank_seq: timeline model compared every cycle plus directed literal checks.
module tb_gsrl_bank_seq;
   localparam int NREQ = 4, NLATCH = 6, IDXW = 3, P = 2;
   localparam int DONE = P + 3;   // model phase holding gnt

`ifdef GSRL_BANK_READBACK_CHECK_EN
   localparam logic RB = 1'b1;
`else
   localparam logic RB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREQ-1:0] req = '0, req_op = '0;
   logic [NREQ*IDXW-1:0] req_idx = '0;
   logic [NLATCH-1:0] latch_q = 6'b101010;
   logic [NREQ-1:0] gnt;
   logic err, busy;
   logic [NLATCH-1:0] latch_s, latch_r, latch_en;

   int checks = 0, errors = 0;

   gsrl_bank_seq #(.NREQ(NREQ), .NLATCH(NLATCH), .IDXW(IDXW), .PULSE_CYC(P)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_idx(req_idx),
      .gnt(gnt), .err(err), .latch_s(latch_s), .latch_r(latch_r),
      .latch_en(latch_en), .latch_q(latch_q), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int i = 0; i < NREQ; i++)
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      return -1;
   endfunction

   // Model: k = cycles since capture (0 = idle); outputs follow directly from k.
   int k = 0, m_id = 0, m_idx = 0, m_ptr = 0, w;
   logic m_op = 1'b0;
   always_comb w = rr_pick(req, m_ptr);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k     <= 0;
         m_ptr <= 0;
      end else if (k == 0) begin
         if (w >= 0) begin
            m_id  <= w;
            m_op  <= req_op[w];
            m_idx <= int'(req_idx[w*IDXW +: IDXW]);
            k     <= 1;
         end
      end else if (k == DONE) begin
         m_ptr <= (m_id + 1) % NREQ;
         k     <= 0;
      end else begin
         k <= k + 1;
      end
   end

   logic [NLATCH-1:0] m_sel, e_s, e_r, e_en;
   logic [NREQ-1:0] e_gnt;
   logic e_err, e_busy, rb_miss;

`ifdef GSRL_BANK_READBACK_CHECK_EN
   always_comb rb_miss = (m_idx < NLATCH) && (latch_q[m_idx] != m_op);
`else
   always_comb rb_miss = 1'b0;
`endif

   always_comb begin
      m_sel  = (m_idx < NLATCH) ? NLATCH'(1 << m_idx) : '0;
      e_s    = (k >= 1 && k <= P + 2 && m_op)  ? m_sel : '0;
      e_r    = (k >= 1 && k <= P + 2 && !m_op) ? m_sel : '0;
      e_en   = (k >= 2 && k <= P + 1) ? m_sel : '0;
      e_gnt  = (k == DONE) ? NREQ'(1 << m_id) : '0;
      e_err  = (k == DONE) && ((m_idx >= NLATCH) || rb_miss);
      e_busy = (k != 0);
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_gnt", gnt, e_gnt);
         chk("m_err", err, e_err);
         chk("m_busy", busy, e_busy);
         chk("m_s", latch_s, e_s);
         chk("m_r", latch_r, e_r);
         chk("m_en", latch_en, e_en);
         chk("inv_one_latch", $countones(latch_s | latch_r | latch_en) <= 1, 1);
         chk("inv_s_and_r", latch_s & latch_r, 0);
      end
   end

   // Issue one command from requester r (DUT idle), drop req after capture, run until idle.
   task automatic run_cmd(input int r, input bit op, input int idx,
                          output logic [NREQ-1:0] gv, output logic ge,
                          output int gc, output int bc);
      gv = '0; ge = 1'b0; gc = 0; bc = 0;
      req_op[r] = op;
      req_idx[r*IDXW +: IDXW] = IDXW'(idx);
      req[r] = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) req[r] = 1'b0;
         if (busy) bc++;
         if (gnt != 0) begin gv = gnt; ge = err; gc = c; end
         if (!busy) break;
      end
   endtask

   logic [NREQ-1:0] gv;
   logic ge;
   int gc, bc, n;
   logic [NREQ-1:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
   logic [NREQ-1:0] rr_got [6];
   int rr_t [6];

   initial begin
      #12;
      chk("rst_gnt", gnt, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s", latch_s, 0);
      chk("rst_r", latch_r, 0);
      chk("rst_en", latch_en, 0);
      @(negedge clk);
      rst = 1'b0;

      // Single set of latch 5 from requester 0, cycle by cycle.
      req_op[0] = 1'b1; req_idx[2:0] = 3'd5; req[0] = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk("t1_s", latch_s, (c <= 4) ? 6'b100000 : 6'b000000);
         chk("t1_r", latch_r, 0);
         chk("t1_en", latch_en, (c == 2 || c == 3) ? 6'b100000 : 6'b000000);
         chk("t1_gnt", gnt, (c == 5) ? 4'b0001 : 4'b0000);
         chk("t1_err", err, 0);
         chk("t1_busy", busy, (c <= 5) ? 1 : 0);
         if (c == 1) req[0] = 1'b0;
      end

      // Reset op on latch 5 from requester 2.
      run_cmd(2, 1'b0, 5, gv, ge, gc, bc);
      chk("t3_gnt", gv, 4'b0100);
      chk("t3_err", ge, 0);
      chk("t3_lat", gc, 5);

      // Invalid index 7 from requester 3 (pointer wraps to 0 afterwards).
      run_cmd(3, 1'b1, 7, gv, ge, gc, bc);
      chk("inv_gnt", gv, 4'b1000);
      chk("inv_err", ge, 1);
      chk("inv_lat", gc, 5);
      chk("inv_busy_cycles", bc, 5);

      // Round-robin with 1011 held continuously.
      req_op = 4'b0011;
      req_idx = {3'd3, 3'd0, 3'd1, 3'd0};
      req = 4'b1011;
      n = 0;
      for (int t = 0; t < 80 && n < 6; t++) begin
         @(negedge clk);
         if (gnt != 0) begin
            rr_got[n] = gnt;
            rr_t[n] = t;
            n++;
            if (n == 6) req = '0;
         end
      end
      chk("rr_count", n, 6);
      for (int i = 0; i < n; i++) begin
         chk("rr_order", rr_got[i], rr_exp[i]);
         if (i > 0) chk("rr_period", rr_t[i] - rr_t[i-1], 6);
      end
      @(negedge clk);

      // Readback: Q low after a set, then Q high.
      latch_q = 6'b000000;
      run_cmd(0, 1'b1, 2, gv, ge, gc, bc);
      chk("rb_q0_gnt", gv, 4'b0001);
      chk("rb_q0_err", ge, RB);
      latch_q = 6'b000100;
      run_cmd(0, 1'b1, 2, gv, ge, gc, bc);
      chk("rb_q1_gnt", gv, 4'b0001);
      chk("rb_q1_err", ge, 0);
      run_cmd(1, 1'b0, 0, gv, ge, gc, bc);
      chk("r1_gnt", gv, 4'b0010);

      // Reset during the first En-high cycle of a command from requester 2.
      req_op[2] = 1'b1; req_idx[8:6] = 3'd4; req[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req[2] = 1'b0;
      @(posedge clk);
      #1;
      chk("ab_en_high", latch_en, 6'b010000);
      #2 rst = 1'b1;
      #1;
      chk("ab_en_drop", latch_en, 0);
      chk("ab_s_drop", latch_s, 0);
      chk("ab_r_drop", latch_r, 0);
      chk("ab_busy", busy, 0);
      chk("ab_gnt", gnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // After reset the pointer is 0, so requester 1 beats requester 3.
      req_op = 4'b1010;
      req_idx[5:3] = 3'd1;
      req_idx[11:9] = 3'd3;
      req = 4'b1010;
      gv = '0;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) req = '0;
         if (gnt != 0 && gv == 0) gv = gnt;
         if (!busy) break;
      end
      chk("post_rst_winner", gv, 4'b0010);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
